// File: rtl/outport_alloc_if.sv
// Request/grant bundle between the five input controllers and one
// output-port allocator. The allocator sits on the slave side.
`ifndef PORTW
`define PORTW 2
`endif

interface outport_alloc_if #(
   parameter int NPORT = 5
);
   logic [NPORT-1:0] req;
   logic [`PORTW:0]  port_0;
   logic [`PORTW:0]  port_1;
   logic [`PORTW:0]  port_2;
   logic [`PORTW:0]  port_3;
   logic [`PORTW:0]  port_4;
   logic [NPORT-1:0] tail;
   logic             dst_rdy;
   logic [NPORT-1:0] grt;
   logic             busy;
   logic [2:0]       owner;

   modport master (
      output req, port_0, port_1, port_2, port_3, port_4, tail, dst_rdy,
      input  grt, busy, owner
   );

   modport slave (
      input  req, port_0, port_1, port_2, port_3, port_4, tail, dst_rdy,
      output grt, busy, owner
   );
endinterface

// File: rtl/outport_alloc.sv
// Per-output-port switch allocator: round-robin picks one input whose
// request targets MY_PORT, then holds the port locked to that input
// until its tail flit has been transferred.
`ifndef PORTW
`define PORTW 2
`endif

module outport_alloc #(
   parameter int              NPORT   = 5,
   parameter logic [`PORTW:0] MY_PORT = '0
) (
   input logic            clk,
   input logic            rst_,
   outport_alloc_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t           r_state;
   logic [2:0]       r_rr_ptr;
   logic [2:0]       r_owner;

   state_t           w_state_nxt;
   logic [2:0]       w_ptr_nxt;
   logic [2:0]       w_owner_nxt;
   logic [2:0]       w_ptr;
   logic [2:0]       w_owner;
   logic [`PORTW:0]  w_port [NPORT];
   logic [NPORT-1:0] w_cand;
   logic [NPORT-1:0] w_own_oh;
   logic [NPORT-1:0] w_grt;
   logic             w_found;
   logic [2:0]       w_pick;
   logic [3:0]       w_sum;
   logic [3:0]       w_idx;

   // Out-of-range pointer/owner values collapse to 0 so the next edge repairs them
   assign w_ptr    = (r_rr_ptr > 3'(NPORT-1)) ? 3'd0 : r_rr_ptr;
   assign w_owner  = (r_owner  > 3'(NPORT-1)) ? 3'd0 : r_owner;
   // One-hot of the raw owner is all-zero for an illegal owner, so nothing is granted
   assign w_own_oh = {{(NPORT-1){1'b0}}, 1'b1} << r_owner;

   // Gather the per-input port fields and mark inputs that want this output
   always_comb begin
      w_port[0] = bus.port_0;
      w_port[1] = bus.port_1;
      w_port[2] = bus.port_2;
      w_port[3] = bus.port_3;
      w_port[4] = bus.port_4;
      w_cand    = '0;
      for (int k = 0; k < NPORT; k++) begin
         w_cand[k] = bus.req[k] & (w_port[k] == MY_PORT);
      end
   end

   // Circular first-one search starting at the round-robin pointer
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = 0; i < NPORT; i++) begin
         w_sum = {1'b0, w_ptr} + 4'(i);
         w_idx = (w_sum >= 4'(NPORT)) ? (w_sum - 4'(NPORT)) : w_sum;
         if (!w_found && w_cand[w_idx[2:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[2:0];
         end
      end
   end

   // Next-state, pointer/owner update and combinational grant
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = w_ptr;
      w_owner_nxt = w_owner;
      w_grt       = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_BUSY;
               w_owner_nxt = w_pick;
            end
         end
         ST_BUSY: begin
            if (bus.dst_rdy && |(w_own_oh & bus.req)) begin
               w_grt = w_own_oh;
            end
            if (|w_grt && |(w_own_oh & bus.tail)) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = (w_owner == 3'(NPORT-1)) ? 3'd0 : (w_owner + 3'd1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, round-robin pointer and owner registers
   always_ff @(posedge clk) begin
      if (rst_) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_ptr_nxt;
         r_owner  <= w_owner_nxt;
      end
   end

   assign bus.grt   = w_grt;
   assign bus.busy  = (r_state == ST_BUSY);
   assign bus.owner = r_owner;

endmodule

// File: tb/tb_outport_alloc.sv
// Bench for outport_alloc: directed vector table, a round-robin wrap
// sequence, and randomized traffic against a behavioural model.
`ifndef PORTW
`define PORTW 2
`endif

module tb_outport_alloc;

   localparam logic [2:0]  M    = 3'd2;
   localparam logic [2:0]  X    = 3'd1;
   localparam logic [14:0] ALLM = {M, M, M, M, M};
   localparam logic [14:0] P1X  = {M, M, M, X, M};

   typedef struct {
      logic        rst;
      logic [4:0]  req;
      logic [14:0] ports;
      logic [4:0]  tail;
      logic        dst;
      logic [4:0]  egrt;
      logic        ebusy;
      logic [2:0]  eown;
   } vec_t;

   logic clk;
   logic rst_;
   int   pass_cnt;
   int   tot_cnt;
   logic prev_busy;
   logic prev_rst;
   logic [2:0] prev_owner;

   outport_alloc_if #(.NPORT(5)) bus ();

   outport_alloc #(.NPORT(5), .MY_PORT(M)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic [4:0] rq, logic [14:0] p, logic [4:0] t,
                               logic d, logic [4:0] eg, logic eb, logic [2:0] eo);
      vec_t v;
      v.rst = r; v.req = rq; v.ports = p; v.tail = t; v.dst = d;
      v.egrt = eg; v.ebusy = eb; v.eown = eo;
      return v;
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(logic r, logic [4:0] rq, logic [14:0] p, logic [4:0] t, logic d);
      rst_        = r;
      bus.req     = rq;
      bus.port_0  = p[2:0];
      bus.port_1  = p[5:3];
      bus.port_2  = p[8:6];
      bus.port_3  = p[11:9];
      bus.port_4  = p[14:12];
      bus.tail    = t;
      bus.dst_rdy = d;
   endtask

   // Compare outputs mid-cycle, check invariants, then advance one clock
   task automatic tick_check(logic [4:0] eg, logic eb, logic [2:0] eo, string tag);
      @(negedge clk);
      chk({tag, ".grt"},   {3'b0, bus.grt},   {3'b0, eg});
      chk({tag, ".busy"},  {7'b0, bus.busy},  {7'b0, eb});
      chk({tag, ".owner"}, {5'b0, bus.owner}, {5'b0, eo});
      chk({tag, ".onehot"}, {7'b0, $onehot0(bus.grt)}, 8'd1);
      chk({tag, ".grt_busy"}, {7'b0, (bus.grt == 5'b0) || bus.busy}, 8'd1);
      if (prev_busy && bus.busy && !prev_rst)
         chk({tag, ".own_stable"}, {5'b0, bus.owner}, {5'b0, prev_owner});
      prev_busy  = bus.busy;
      prev_owner = bus.owner;
      prev_rst   = rst_;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t       tbl[$];
      logic [4:0] seq[18];
      logic [4:0] t;
      logic [2:0] eo;
      logic [2:0] rp[5];
      logic [14:0] pk;
      logic [4:0] rq, rt, eg;
      logic       rd, rr;
      bit         m_lock;
      int         m_own, m_ptr, k;
      bit         found;

      pass_cnt = 0; tot_cnt = 0;
      prev_busy = 1'b0; prev_rst = 1'b1; prev_owner = '0;

      drive(1'b1, 5'b0, ALLM, 5'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // rows: rst, req, ports, tail, dst, exp grt, exp busy, exp owner
      tbl.push_back(mk(0, 5'b00000, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd0));
      tbl.push_back(mk(0, 5'b00100, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd0));
      tbl.push_back(mk(0, 5'b00100, ALLM, 5'b00000, 1, 5'b00100, 1, 3'd2));
      tbl.push_back(mk(0, 5'b00100, ALLM, 5'b00100, 1, 5'b00100, 1, 3'd2));
      tbl.push_back(mk(0, 5'b00000, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd2));
      tbl.push_back(mk(0, 5'b11111, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd2));
      tbl.push_back(mk(0, 5'b11111, ALLM, 5'b00000, 1, 5'b01000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b11111, ALLM, 5'b00000, 0, 5'b00000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b11111, ALLM, 5'b01000, 0, 5'b00000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b10111, ALLM, 5'b01000, 1, 5'b00000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b11111, ALLM, 5'b00000, 1, 5'b01000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b11111, ALLM, 5'b01000, 1, 5'b01000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b10010, P1X,  5'b00000, 1, 5'b00000, 0, 3'd3));
      tbl.push_back(mk(0, 5'b10010, P1X,  5'b00000, 1, 5'b10000, 1, 3'd4));
      tbl.push_back(mk(0, 5'b10010, P1X,  5'b10000, 1, 5'b10000, 1, 3'd4));
      tbl.push_back(mk(0, 5'b00010, P1X,  5'b00000, 1, 5'b00000, 0, 3'd4));
      tbl.push_back(mk(0, 5'b00010, P1X,  5'b00000, 1, 5'b00000, 0, 3'd4));
      tbl.push_back(mk(0, 5'b01100, ALLM, 5'b01100, 1, 5'b00000, 0, 3'd4));
      tbl.push_back(mk(0, 5'b01100, ALLM, 5'b01100, 1, 5'b00100, 1, 3'd2));
      tbl.push_back(mk(0, 5'b01100, ALLM, 5'b01100, 1, 5'b00000, 0, 3'd2));
      tbl.push_back(mk(0, 5'b01100, ALLM, 5'b01100, 1, 5'b01000, 1, 3'd3));
      tbl.push_back(mk(0, 5'b00000, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd3));
      tbl.push_back(mk(0, 5'b00001, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd3));
      tbl.push_back(mk(0, 5'b00001, ALLM, 5'b00000, 1, 5'b00001, 1, 3'd0));
      tbl.push_back(mk(1, 5'b00001, ALLM, 5'b00000, 1, 5'b00001, 1, 3'd0));
      tbl.push_back(mk(0, 5'b00001, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd0));
      tbl.push_back(mk(0, 5'b00001, ALLM, 5'b00000, 1, 5'b00001, 1, 3'd0));
      tbl.push_back(mk(0, 5'b00001, ALLM, 5'b00001, 1, 5'b00001, 1, 3'd0));
      tbl.push_back(mk(0, 5'b00000, ALLM, 5'b00000, 1, 5'b00000, 0, 3'd0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].ports, tbl[i].tail, tbl[i].dst);
         tick_check(tbl[i].egrt, tbl[i].ebusy, tbl[i].eown, $sformatf("vec%0d", i));
      end

      // Round-robin wrap: all inputs request, two-flit packets
      drive(1'b1, 5'b0, ALLM, 5'b0, 1'b1);
      tick_check(5'b0, 1'b0, 3'd0, "rr_rst");
      seq = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd2, 5'd2, 5'd0, 5'd4, 5'd4, 5'd0,
              5'd8, 5'd8, 5'd0, 5'd16, 5'd16, 5'd0, 5'd1, 5'd1};
      eo = 3'd0;
      for (int i = 0; i < 18; i++) begin
         t = (i > 0 && seq[i] != 5'd0 && seq[i] == seq[i-1]) ? seq[i] : 5'd0;
         if (seq[i] != 5'd0) eo = 3'($clog2(seq[i]));
         drive(1'b0, 5'b11111, ALLM, t, 1'b1);
         tick_check(seq[i], seq[i] != 5'd0, eo, $sformatf("rr%0d", i));
      end

      // Randomized traffic against the behavioural model
      drive(1'b1, 5'b0, ALLM, 5'b0, 1'b0);
      tick_check(5'b0, 1'b0, 3'd0, "rnd_rst");
      m_lock = 1'b0; m_own = 0; m_ptr = 0;
      for (int c = 0; c < 1500; c++) begin
         rr = ($urandom_range(0, 49) == 0);
         rq = 5'($urandom);
         for (int j = 0; j < 5; j++)
            rp[j] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 4)) : M;
         pk = {rp[4], rp[3], rp[2], rp[1], rp[0]};
         rt = 5'($urandom) & 5'($urandom);
         rd = ($urandom_range(0, 3) != 0);
         drive(rr, rq, pk, rt, rd);
         eg = (m_lock && rd && rq[m_own]) ? (5'd1 << m_own) : 5'd0;
         tick_check(eg, m_lock, 3'(m_own), "rnd");
         if (rr) begin
            m_lock = 1'b0; m_own = 0; m_ptr = 0;
         end else if (!m_lock) begin
            found = 1'b0;
            for (int j = 0; j < 5; j++) begin
               k = (m_ptr + j) % 5;
               if (!found && rq[k] && rp[k] == M) begin
                  found = 1'b1; m_lock = 1'b1; m_own = k;
               end
            end
         end else if (eg != 5'd0 && rt[m_own]) begin
            m_lock = 1'b0;
            m_ptr  = (m_own + 1) % 5;
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
